// File: rtl/cpu_seq_ctrl_if.sv
// Bundle of the instruction-source, datapath-enable and RAM handshake signals
// between cpu_seq_ctrl (master) and the rest of the CPU (slave).
//   instruction side : ins, ins_valid -> ; <- en_fetch, ir_out, offset_out
//   datapath enables : en_pc_inc, en_pc_load, en_alu, en_reg_wr, zero_flag
//   RAM side         : en_ram, wen_ram, en_mar_pulse, mdr_ctrl, ram_ack
//   control/status   : en_in, halt, err, state
interface cpu_seq_ctrl_if;
  logic        en_in;
  logic [15:0] ins;
  logic        ins_valid;
  logic        ram_ack;
  logic        zero_flag;

  logic        en_fetch;
  logic [15:0] ir_out;
  logic [7:0]  offset_out;
  logic        en_pc_inc;
  logic        en_pc_load;
  logic        en_alu;
  logic        en_reg_wr;
  logic        en_ram;
  logic        wen_ram;
  logic        en_mar_pulse;
  logic [1:0]  mdr_ctrl;
  logic        halt;
  logic        err;
  logic [2:0]  state;

  modport master (
    input  en_in, ins, ins_valid, ram_ack, zero_flag,
    output en_fetch, ir_out, offset_out, en_pc_inc, en_pc_load, en_alu,
           en_reg_wr, en_ram, wen_ram, en_mar_pulse, mdr_ctrl, halt, err, state
  );

  modport slave (
    output en_in, ins, ins_valid, ram_ack, zero_flag,
    input  en_fetch, ir_out, offset_out, en_pc_inc, en_pc_load, en_alu,
           en_reg_wr, en_ram, wen_ram, en_mar_pulse, mdr_ctrl, halt, err, state
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the 16-bit course CPU. Fetches one
// instruction into the IR and steps it through DECODE/EXEC/MEM/WB, driving
// the PC, ALU, register-file, MAR/MDR and RAM enables.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - cpu_seq_ctrl_if.master (instruction, datapath and RAM signals)
// Parameter MEM_TIMEOUT (1..255): MEM cycles without ram_ack before faulting.
//
// state  | meaning
// IDLE   | not running, all enables low
// FETCH  | requesting an instruction word
// DECODE | opcode decode, single PC action
// EXEC   | ALU operation
// MEM    | RAM access, waiting for ram_ack (bounded by MEM_TIMEOUT)
// WB     | register-file write
// HALT   | stopped; err flags a memory timeout or illegal state
module cpu_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [3:0] op;
  logic       is_alu, is_load, is_store, is_jmp, is_bz, is_halt;

  assign op       = ir_q[15:12];
  assign is_alu   = ~op[3];
  assign is_load  = (op == 4'b1000);
  assign is_store = (op == 4'b1001);
  assign is_jmp   = (op == 4'b1010);
  assign is_bz    = (op == 4'b1011);
  assign is_halt  = (op == 4'b1100);

  always_comb begin
    state_e bnd;
    bnd     = bus.en_in ? S_FETCH : S_IDLE;
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;       // counter only survives while staying in MEM
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (bus.en_in) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ins_valid) begin
          ir_d    = bus.ins;
          state_d = S_DECODE;
        end else if (!bus.en_in) begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_alu)                   state_d = S_EXEC;
        else if (is_load || is_store) state_d = S_MEM;
        else if (is_halt)             state_d = S_HALT;
        else                          state_d = bnd;
      end
      S_EXEC:   state_d = S_WB;
      S_MEM: begin
        // ack is checked first so it wins over a timeout in the same cycle
        if (bus.ram_ack) begin
          state_d = is_load ? S_WB : bnd;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_MEM;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_WB:     state_d = bnd;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore decode of the state register; BZ's PC load is the one path that
  // also looks at a live input (zero_flag).
  always_comb begin
    bus.en_fetch     = 1'b0;
    bus.en_pc_inc    = 1'b0;
    bus.en_pc_load   = 1'b0;
    bus.en_alu       = 1'b0;
    bus.en_reg_wr    = 1'b0;
    bus.en_ram       = 1'b0;
    bus.wen_ram      = 1'b0;
    bus.en_mar_pulse = 1'b0;
    bus.mdr_ctrl     = 2'b00;
    bus.halt         = 1'b0;
    case (state_q)
      S_FETCH:  bus.en_fetch = 1'b1;
      S_DECODE: begin
        bus.en_pc_load = is_jmp | (is_bz & bus.zero_flag);
        bus.en_pc_inc  = ~is_halt & ~(is_jmp | (is_bz & bus.zero_flag));
      end
      S_EXEC:   bus.en_alu = 1'b1;
      S_MEM: begin
        bus.en_ram       = 1'b1;
        bus.wen_ram      = is_store;
        bus.mdr_ctrl     = is_store ? 2'b10 : 2'b01;
        bus.en_mar_pulse = (cnt_q == 8'd0);
      end
      S_WB:     bus.en_reg_wr = 1'b1;
      S_HALT:   bus.halt = 1'b1;
      default:  bus.halt = 1'b0;
    endcase
  end

  assign bus.ir_out     = ir_q;
  assign bus.offset_out = ir_q[7:0];
  assign bus.err        = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_seq_ctrl_if bus ();
  cpu_seq_ctrl #(.MEM_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_ir = 16'h0000;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  // {en_fetch, pc_inc, pc_load, alu, reg_wr, ram, wen, mar, mdr[1:0], halt, err}
  localparam logic [11:0] V_NONE = 12'h000, V_FETCH = 12'h800, V_INC = 12'h400,
                          V_LOAD = 12'h200, V_ALU = 12'h100, V_WR = 12'h080,
                          V_RAM = 12'h040, V_WEN = 12'h020, V_MAR = 12'h010,
                          V_MDR_WR = 12'h008, V_MDR_RD = 12'h004,
                          V_HALT = 12'h002, V_ERR = 12'h001;

  typedef struct packed {
    logic       iv;
    logic       ack;
    logic [2:0] st;
    logic [11:0] v;
  } step_t;

  function automatic logic [11:0] obs_vec();
    return {bus.en_fetch, bus.en_pc_inc, bus.en_pc_load, bus.en_alu, bus.en_reg_wr,
            bus.en_ram, bus.wen_ram, bus.en_mar_pulse, bus.mdr_ctrl, bus.halt, bus.err};
  endfunction

  // Reference model: expands one instruction into its expected per-cycle
  // phase list from the opcode rules, then drives and checks cycle by cycle.
  // Entered at a negedge with the DUT in FETCH. drop >= 0 forces en_in low
  // from that step onward so the final boundary lands in IDLE.
  task automatic run_instr(input logic [15:0] iw, input int fw, input int aw,
                           input logic z, input int drop);
    step_t q[$];
    step_t s;
    logic [3:0] op;
    logic [11:0] mv;
    logic en;
    op = iw[15:12];
    for (int k = 0; k < fw; k++) begin
      s = '{iv: 1'b0, ack: 1'b0, st: ST_FETCH, v: V_FETCH}; q.push_back(s);
    end
    s = '{iv: 1'b1, ack: 1'b0, st: ST_FETCH, v: V_FETCH}; q.push_back(s);
    if (op == 4'hA || (op == 4'hB && z)) s = '{iv: 1'b0, ack: 1'b0, st: ST_DECODE, v: V_LOAD};
    else if (op == 4'hC)                 s = '{iv: 1'b0, ack: 1'b0, st: ST_DECODE, v: V_NONE};
    else                                 s = '{iv: 1'b0, ack: 1'b0, st: ST_DECODE, v: V_INC};
    q.push_back(s);
    if (op < 4'h8) begin
      s = '{iv: 1'b0, ack: 1'b0, st: ST_EXEC, v: V_ALU}; q.push_back(s);
      s = '{iv: 1'b0, ack: 1'b0, st: ST_WB,   v: V_WR};  q.push_back(s);
    end else if (op == 4'h8 || op == 4'h9) begin
      for (int k = 0; k <= aw; k++) begin
        mv = V_RAM | ((op == 4'h9) ? (V_WEN | V_MDR_WR) : V_MDR_RD) | ((k == 0) ? V_MAR : V_NONE);
        s = '{iv: 1'b0, ack: (k == aw), st: ST_MEM, v: mv}; q.push_back(s);
      end
      if (op == 4'h8) begin
        s = '{iv: 1'b0, ack: 1'b0, st: ST_WB, v: V_WR}; q.push_back(s);
      end
    end
    foreach (q[i]) begin
      if (drop >= 0 && i >= drop)                    en = 1'b0;
      else if ((q[i].st == ST_FETCH && !q[i].iv) || i == q.size() - 1) en = 1'b1;
      else                                           en = 1'($urandom);
      bus.en_in     = en;
      bus.ins_valid = q[i].iv;
      bus.ins       = q[i].iv ? iw : 16'($urandom);
      bus.ram_ack   = q[i].ack;
      bus.zero_flag = (q[i].st == ST_DECODE) ? z : 1'($urandom);
      #1;
      n_cmp++;
      if ({bus.state, obs_vec(), bus.ir_out, bus.offset_out} !== {q[i].st, q[i].v, exp_ir, exp_ir[7:0]}) begin
        n_bad++;
        $display("FAIL instr %h step %0d: got st=%0d v=%h ir=%h off=%h, want st=%0d v=%h ir=%h",
                 iw, i, bus.state, obs_vec(), bus.ir_out, bus.offset_out, q[i].st, q[i].v, exp_ir);
      end
      if (q[i].iv) exp_ir = iw;
      @(negedge clk);
    end
    bus.ins_valid = 1'b0;
    bus.ram_ack   = 1'b0;
  endtask

  // Releases reset at a negedge and steps IDLE -> FETCH with en_in high.
  task automatic restart();
    rst = 1'b1;
    bus.en_in = 1'b1;
    bus.ins_valid = 1'b0;
    bus.ram_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.en_in = 1'b0; bus.ins = 16'hFFFF; bus.ins_valid = 1'b0;
    bus.ram_ack = 1'b0; bus.zero_flag = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.state, obs_vec(), bus.ir_out, bus.offset_out} !== {ST_IDLE, V_NONE, 16'h0000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_values: got st=%0d v=%h ir=%h, want all zero", bus.state, obs_vec(), bus.ir_out);
    end
    exp_ir = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ins_valid = 1'($urandom);
      bus.ins = 16'($urandom);
      #1;
      n_cmp++;
      if ({bus.state, obs_vec(), bus.ir_out} !== {ST_IDLE, V_NONE, exp_ir}) begin
        n_bad++;
        $display("FAIL idle_hold %0d: got st=%0d v=%h ir=%h, want IDLE", k, bus.state, obs_vec(), bus.ir_out);
      end
      @(negedge clk);
    end
    bus.ins_valid = 1'b0;
  endtask

  task automatic test_alu();
    bus.en_in = 1'b1;
    #1;
    n_cmp++;
    if ({bus.state, obs_vec()} !== {ST_IDLE, V_NONE}) begin
      n_bad++;
      $display("FAIL alu_start: got st=%0d v=%h, want st=0 v=000", bus.state, obs_vec());
    end
    @(negedge clk);
    run_instr(16'h0401, 0, 0, 1'b0, -1);
    #1;
    n_cmp++;
    if ({bus.state, bus.ir_out, bus.offset_out} !== {ST_FETCH, 16'h0401, 8'h01}) begin
      n_bad++;
      $display("FAIL alu_after: got st=%0d ir=%h off=%h, want st=1 ir=0401 off=01",
               bus.state, bus.ir_out, bus.offset_out);
    end
  endtask

  task automatic test_load_store();
    run_instr(16'h8005, 0, 3, 1'b0, -1);
    run_instr(16'h9abc, 1, 7, 1'b0, -1);   // ack on the last allowed MEM cycle
    run_instr(16'h8077, 0, 7, 1'b1, -1);
  endtask

  task automatic test_bz();
    run_instr(16'hB00D, 0, 0, 1'b1, -1);
    run_instr(16'hB00D, 1, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_instr(16'h0401, 0, 0, 1'b0, -1);
    run_instr(16'h8005, 0, 0, 1'b0, -1);
    run_instr(16'h9006, 0, 0, 1'b0, -1);
    run_instr(16'hA0FF, 0, 0, 1'b0, -1);
    run_instr(16'hD000, 0, 0, 1'b1, -1);
    run_instr(16'h7123, 0, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [15:0] iw;
    for (int n = 0; n < 40; n++) begin
      iw = 16'($urandom);
      if (iw[15:12] == 4'hC) iw[15:12] = 4'hD;
      run_instr(iw, $urandom_range(0, 2), $urandom_range(0, 7), 1'($urandom), -1);
    end
  endtask

  task automatic test_en_drop();
    // ALU op with en_in dropped from EXEC: WB completes, then IDLE
    run_instr(16'h0123, 0, 0, 1'b0, 2);
    bus.en_in = 1'b0;
    #1;
    n_cmp++;
    if ({bus.state, obs_vec()} !== {ST_IDLE, V_NONE}) begin
      n_bad++;
      $display("FAIL en_drop_idle: got st=%0d v=%h, want st=0 v=000", bus.state, obs_vec());
    end
    @(negedge clk);
    bus.en_in = 1'b1;
    #1;
    n_cmp++;
    if (bus.state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL en_raise_idle: got st=%0d, want 0", bus.state);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.state, obs_vec()} !== {ST_FETCH, V_FETCH}) begin
      n_bad++;
      $display("FAIL en_raise_fetch: got st=%0d v=%h, want st=1 v=800", bus.state, obs_vec());
    end
    // en_in dropped while waiting in FETCH
    @(negedge clk);
    bus.en_in = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL fetch_drop: got st=%0d, want 0", bus.state);
    end
    @(negedge clk);
    bus.en_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [11:0] mv;
    bus.en_in = 1'b1; bus.ins_valid = 1'b1; bus.ins = 16'h9006; bus.ram_ack = 1'b0;
    @(negedge clk);
    bus.ins_valid = 1'b0;
    bus.ins = 16'($urandom);
    exp_ir = 16'h9006;
    #1;
    n_cmp++;
    if ({bus.state, obs_vec()} !== {ST_DECODE, V_INC}) begin
      n_bad++;
      $display("FAIL tmo_decode: got st=%0d v=%h, want st=2 v=400", bus.state, obs_vec());
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      bus.en_in = 1'($urandom);
      mv = V_RAM | V_WEN | V_MDR_WR | ((k == 0) ? V_MAR : V_NONE);
      #1;
      n_cmp++;
      if ({bus.state, obs_vec()} !== {ST_MEM, mv}) begin
        n_bad++;
        $display("FAIL tmo_mem %0d: got st=%0d v=%h, want st=4 v=%h", k, bus.state, obs_vec(), mv);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      bus.en_in = 1'($urandom);
      bus.ram_ack = 1'($urandom);
      bus.ins_valid = 1'($urandom);
      #1;
      n_cmp++;
      if ({bus.state, obs_vec(), bus.ir_out} !== {ST_HALT, V_HALT | V_ERR, exp_ir}) begin
        n_bad++;
        $display("FAIL tmo_halt %0d: got st=%0d v=%h ir=%h, want st=6 v=003", k, bus.state, obs_vec(), bus.ir_out);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    exp_ir = 16'h0000;
    n_cmp++;
    if ({bus.state, obs_vec(), bus.ir_out} !== {ST_IDLE, V_NONE, 16'h0000}) begin
      n_bad++;
      $display("FAIL tmo_reset: got st=%0d v=%h ir=%h, want all zero", bus.state, obs_vec(), bus.ir_out);
    end
    @(negedge clk);
    restart();
  endtask

  task automatic test_async_reset();
    bus.en_in = 1'b1; bus.ins_valid = 1'b1; bus.ins = 16'h9006; bus.ram_ack = 1'b0;
    @(negedge clk);
    bus.ins_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.state, bus.en_ram, bus.wen_ram} !== {ST_MEM, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL arst_pre: got st=%0d en_ram=%b wen=%b, want st=4 1 1", bus.state, bus.en_ram, bus.wen_ram);
    end
    #1 rst = 1'b0;
    #1;
    exp_ir = 16'h0000;
    n_cmp++;
    if ({bus.state, obs_vec(), bus.ir_out} !== {ST_IDLE, V_NONE, 16'h0000}) begin
      n_bad++;
      $display("FAIL arst_mid: got st=%0d v=%h ir=%h, want all zero", bus.state, obs_vec(), bus.ir_out);
    end
    @(negedge clk);
    restart();
  endtask

  task automatic test_halt_op();
    bus.en_in = 1'b1; bus.ins_valid = 1'b1; bus.ins = 16'hC400;
    @(negedge clk);
    bus.ins_valid = 1'b0;
    bus.zero_flag = 1'($urandom);
    exp_ir = 16'hC400;
    #1;
    n_cmp++;
    if ({bus.state, obs_vec()} !== {ST_DECODE, V_NONE}) begin
      n_bad++;
      $display("FAIL halt_decode: got st=%0d v=%h, want st=2 v=000", bus.state, obs_vec());
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.en_in = 1'($urandom);
      bus.ins_valid = 1'($urandom);
      #1;
      n_cmp++;
      if ({bus.state, obs_vec(), bus.ir_out} !== {ST_HALT, V_HALT, exp_ir}) begin
        n_bad++;
        $display("FAIL halt_hold %0d: got st=%0d v=%h ir=%h, want st=6 v=002", k, bus.state, obs_vec(), bus.ir_out);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_bz();
    test_back_to_back();
    test_random();
    test_en_drop();
    test_timeout();
    test_async_reset();
    test_halt_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control sequencer for the 16-bit course CPU. It fetches one instruction word at a time, holds it in an internal instruction register, and steps it through DECODE, EXEC, MEM and WB phases. In each phase it drives the enables for the PC, ALU, register file, MAR/MDR and RAM. It sits between the instruction source, the datapath and the data RAM, and replaces ad-hoc enable generation in the CPU top.

## Interface
- MEM_TIMEOUT, 8: maximum MEM-state cycles without `ram_ack` before faulting; legal range 1..255.
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_in  in  1  run enable; sampled at instruction boundaries.
- ins  in  16  instruction word from instruction source.
- ins_valid  in  1  `ins` is valid this cycle.
- ram_ack  in  1  RAM completed the current access.
- zero_flag  in  1  ALU zero flag, used by BZ.
- en_fetch  out  1  fetch request (high in FETCH).
- ir_out  out  16  latched instruction register.
- offset_out  out  8  `ir_out[7:0]`.
- en_pc_inc  out  1  PC += 1.
- en_pc_load  out  1  PC <= offset (jump taken).
- en_alu  out  1  ALU operation enable.
- en_reg_wr  out  1  register file write.
- en_ram  out  1  RAM access enable.
- wen_ram  out  1  RAM write enable.
- en_mar_pulse  out  1  one-cycle MAR load.
- mdr_ctrl  out  2  00 idle, 01 MDR<-RAM, 10 MDR->RAM.
- halt  out  1  sequencer halted.
- err  out  1  halted due to memory timeout.
- state  out  3  current state, for debug.

## Operation
- Opcode is `ir[15:12]`:
  - 0000–0111: ALU
  - 1000: LOAD
  - 1001: STORE
  - 1010: JMP
  - 1011: BZ
  - 1100: HALT
  - 1101–1111: NOP
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7 and above go to HALT with err=1.
- Outputs are Moore-decoded from the state register, `ir` and the MEM wait counter. Exception: `en_pc_load` in DECODE for BZ also depends on `zero_flag`.
- "Boundary" means the next state would be FETCH. At a boundary the next state is FETCH if `en_in`=1, otherwise IDLE.
- IDLE: all enables 0. Go to FETCH when `en_in`=1.
- FETCH: `en_fetch`=1.
  - `ins_valid`=1: `ir`<=`ins`, go to DECODE.
  - `ins_valid`=0 and `en_in`=0: go to IDLE.
  - Otherwise stay in FETCH.
- DECODE: exactly one PC action per instruction.
  - JMP, and BZ with `zero_flag`=1: `en_pc_load`=1.
  - HALT opcode: no PC action.
  - All other opcodes: `en_pc_inc`=1.
  - Next state: ALU→EXEC, LOAD/STORE→MEM, HALT→HALT, JMP/BZ/NOP→boundary.
- EXEC: `en_alu`=1. Go to WB.
- MEM:
  - `en_ram`=1 throughout. `wen_ram`=1 for STORE.
  - `mdr_ctrl`=01 for LOAD, 10 for STORE.
  - `en_mar_pulse`=1 only while wait counter = 0 (first MEM cycle).
  - Counter increments each MEM cycle and clears on leaving MEM.
  - `ram_ack`=1: LOAD→WB, STORE→boundary.
  - No ack with counter = MEM_TIMEOUT−1: go to HALT and set `err`.
- WB: `en_reg_wr`=1. Go to boundary.
- HALT: `halt`=1, all enables 0. Only reset leaves HALT; `err` stays set.

## Timing
- Reset value: state=IDLE, `ir`=0, counter=0, every output 0. Reset is asynchronous, so an assert mid-instruction clears everything immediately with no partial writeback.
- Minimum cycles per instruction, with `ins_valid` and `ram_ack` high on the first cycle:
  - ALU: 4 (F, D, E, W)
  - LOAD: 4 (F, D, M, W)
  - STORE: 3
  - JMP, BZ, NOP: 2
  - HALT: 2 to reach HALT
- Back-to-back instructions: FETCH follows the last phase with no bubble.
- `ins` must be stable only on the cycle where `ins_valid`=1. `ir` updates on that edge.
- `ram_ack` and the timeout landing in the same cycle: ack wins.
- `en_in` is ignored mid-instruction and takes effect only at a boundary or while waiting in FETCH.

## Test plan
- Reset low, then high with `en_in`=1 and `ins_valid`=1, `ins`=16'h0401 (ALU) → FETCH, DECODE (`en_pc_inc`), EXEC (`en_alu`), WB (`en_reg_wr`), FETCH; `ir_out`=16'h0401, `offset_out`=8'h01.
- LOAD 16'h8005 with `ram_ack` delayed 3 cycles → MEM lasts 4 cycles, `en_mar_pulse` only in the first, `mdr_ctrl`=01 throughout, then WB.
- STORE 16'h9006 with `ram_ack` never high and MEM_TIMEOUT=8 → 8 MEM cycles with `wen_ram`=1, then HALT with `halt`=1 and `err`=1, held until reset.
- BZ 16'hB00D: with `zero_flag`=1 → `en_pc_load`=1 and `en_pc_inc`=0 in DECODE; with `zero_flag`=0 → `en_pc_inc`=1; both are 2-cycle instructions.
- Drop `en_in` during EXEC of an ALU op → WB completes, then IDLE. Raise it again → FETCH on the next cycle.
- Assert `rst` in the MEM state of a STORE → `en_ram`, `wen_ram` and state are 0 asynchronously before the next edge. HALT opcode 16'hC400 → `halt`=1, `err`=0.
